// File: rtl/crc_engine.sv
// Streaming CRC sink: folds BITS_PER_CYCLE bits per clock; result strobes one cycle after the final chunk.
// data_ready_o is low for STEPS-1 cycles after each accepted word; abort_i drops the frame without a strobe.
module crc_engine #(
   parameter int                   CRC_WIDTH      = 8,
   parameter logic [CRC_WIDTH-1:0] POLYNOMIAL     = CRC_WIDTH'(8'h07),
   parameter logic [CRC_WIDTH-1:0] INIT           = '0,
   parameter logic [CRC_WIDTH-1:0] XOR_OUT        = '0,
   parameter bit                   REFLECT_IN     = 1'b0,
   parameter bit                   REFLECT_OUT    = 1'b0,
   parameter logic [CRC_WIDTH-1:0] RESIDUE        = '0,
   parameter int                   DATA_WIDTH     = 8,
   parameter int                   BITS_PER_CYCLE = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  data_valid_i,
   output logic                  data_ready_o,
   input  logic                  last_i,
   input  logic                  abort_i,
   output logic [CRC_WIDTH-1:0]  crc_o,
   output logic                  crc_valid_o,
   output logic                  match_o
);

   localparam int STEPS = DATA_WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(STEPS + 1);

   if (CRC_WIDTH < 3 || CRC_WIDTH > 32 || BITS_PER_CYCLE < 1 ||
       DATA_WIDTH < BITS_PER_CYCLE || (DATA_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("crc_engine: illegal parameter combination");
   end

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t                 r_state;
   logic [CRC_WIDTH-1:0]   r_crc;
   logic [DATA_WIDTH-1:0]  r_buf;
   logic                   r_last;
   logic [CNT_W-1:0]       r_cnt;
   logic [CRC_WIDTH-1:0]   r_crc_out;
   logic                   r_crc_vld;
   logic                   r_match;

   logic [DATA_WIDTH-1:0]     w_word;
   logic [BITS_PER_CYCLE-1:0] w_chunk;
   logic [CRC_WIDTH-1:0]      w_next;
   logic [CRC_WIDTH-1:0]      w_f;
   logic                      w_accept;
   logic                      w_final;

   function automatic logic [CRC_WIDTH-1:0] fold(input logic [CRC_WIDTH-1:0] c,
                                                 input logic [BITS_PER_CYCLE-1:0] d);
      logic [CRC_WIDTH-1:0] r;
      logic                 fb;
      r = c;
      for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
         fb = r[CRC_WIDTH-1] ^ d[i];
         r  = {r[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLYNOMIAL : '0);
      end
      return r;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] rev_data(input logic [DATA_WIDTH-1:0] v);
      logic [DATA_WIDTH-1:0] r;
      for (int i = 0; i < DATA_WIDTH; i++) r[i] = v[DATA_WIDTH-1-i];
      return r;
   endfunction

   function automatic logic [CRC_WIDTH-1:0] rev_crc(input logic [CRC_WIDTH-1:0] v);
      logic [CRC_WIDTH-1:0] r;
      for (int i = 0; i < CRC_WIDTH; i++) r[i] = v[CRC_WIDTH-1-i];
      return r;
   endfunction

   // Reflection happens once at capture so the shift path is always MSB-first.
   assign w_word   = REFLECT_IN ? rev_data(data_i) : data_i;
   assign w_accept = (r_state == S_IDLE) && data_valid_i && !abort_i;
   assign w_chunk  = (r_state == S_IDLE) ? w_word[DATA_WIDTH-1 -: BITS_PER_CYCLE]
                                         : r_buf[DATA_WIDTH-1 -: BITS_PER_CYCLE];
   assign w_next   = fold(r_crc, w_chunk);
   assign w_f      = REFLECT_OUT ? rev_crc(w_next) : w_next;
   assign w_final  = (r_state == S_IDLE) ? (w_accept && last_i && (STEPS == 1))
                                         : (r_cnt == CNT_W'(1)) && r_last;

   assign data_ready_o = (r_state == S_IDLE);
   assign crc_o        = r_crc_out;
   assign crc_valid_o  = r_crc_vld;
   assign match_o      = r_match;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_crc     <= INIT;
         r_buf     <= '0;
         r_last    <= 1'b0;
         r_cnt     <= '0;
         r_crc_out <= '0;
         r_crc_vld <= 1'b0;
         r_match   <= 1'b0;
      end else begin
         r_crc_vld <= 1'b0;
         if (abort_i) begin
            r_crc   <= INIT;
            r_state <= S_IDLE;
         end else begin
            if (w_accept || r_state == S_SHIFT) begin
               // Reloading INIT on the final chunk lets the next frame start with no gap.
               r_crc <= w_final ? INIT : w_next;
               if (w_final) begin
                  r_crc_out <= w_f ^ XOR_OUT;
                  r_match   <= (w_f == RESIDUE);
                  r_crc_vld <= 1'b1;
               end
            end
            if (r_state == S_IDLE) begin
               if (w_accept && STEPS > 1) begin
                  r_buf   <= w_word << BITS_PER_CYCLE;
                  r_last  <= last_i;
                  r_cnt   <= CNT_W'(STEPS - 1);
                  r_state <= S_SHIFT;
               end
            end else begin
               r_buf <= r_buf << BITS_PER_CYCLE;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) r_state <= S_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: four configurations checked against a bitwise CRC reference model.
module tb_crc_engine;

   typedef logic [7:0] bytes_t [$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0]  din [4];
   logic        dv  [4];
   logic        ls  [4];
   logic        ab  [4];
   logic        rdy [4];
   logic        cvld[4];
   logic        mt  [4];
   logic [7:0]  crc0, crc3;
   logic [15:0] crc1;
   logic [31:0] crc2;
   logic [31:0] crc_w[4];

   int nasrt = 0;
   int nfail = 0;

   always_comb begin
      crc_w[0] = {24'h0, crc0};
      crc_w[1] = {16'h0, crc1};
      crc_w[2] = crc2;
      crc_w[3] = {24'h0, crc3};
   end

   crc_engine u_crc8 (
      .clk_i(clk), .rst_i(rst), .data_i(din[0]), .data_valid_i(dv[0]), .data_ready_o(rdy[0]),
      .last_i(ls[0]), .abort_i(ab[0]), .crc_o(crc0), .crc_valid_o(cvld[0]), .match_o(mt[0]));

   crc_engine #(.CRC_WIDTH(16), .POLYNOMIAL(16'h1021), .INIT(16'hFFFF), .BITS_PER_CYCLE(1)) u_crc16 (
      .clk_i(clk), .rst_i(rst), .data_i(din[1]), .data_valid_i(dv[1]), .data_ready_o(rdy[1]),
      .last_i(ls[1]), .abort_i(ab[1]), .crc_o(crc1), .crc_valid_o(cvld[1]), .match_o(mt[1]));

   crc_engine #(.CRC_WIDTH(32), .POLYNOMIAL(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1),
                .RESIDUE(32'hDEBB20E3), .BITS_PER_CYCLE(4)) u_crc32 (
      .clk_i(clk), .rst_i(rst), .data_i(din[2]), .data_valid_i(dv[2]), .data_ready_o(rdy[2]),
      .last_i(ls[2]), .abort_i(ab[2]), .crc_o(crc2), .crc_valid_o(cvld[2]), .match_o(mt[2]));

   crc_engine #(.BITS_PER_CYCLE(2)) u_crc8b2 (
      .clk_i(clk), .rst_i(rst), .data_i(din[3]), .data_valid_i(dv[3]), .data_ready_o(rdy[3]),
      .last_i(ls[3]), .abort_i(ab[3]), .crc_o(crc3), .crc_valid_o(cvld[3]), .match_o(mt[3]));

   function automatic int steps_of(input int k);
      case (k)
         1:       return 8;
         2:       return 2;
         3:       return 4;
         default: return 1;
      endcase
   endfunction

   // Textbook bit-at-a-time CRC: returns the published CRC and whether the reflected register hits the residue.
   function automatic void model(input int k, input bytes_t q, output logic [31:0] crc, output logic m);
      int          w;
      logic [31:0] poly, init, xo, res, mask, r, f;
      bit          ri, ro, b;
      case (k)
         1:       begin w = 16; poly = 32'h1021;     init = 32'hFFFF;     xo = 0;            ri = 0; ro = 0; res = 0;            end
         2:       begin w = 32; poly = 32'h04C11DB7; init = 32'hFFFFFFFF; xo = 32'hFFFFFFFF; ri = 1; ro = 1; res = 32'hDEBB20E3; end
         default: begin w = 8;  poly = 32'h07;       init = 0;            xo = 0;            ri = 0; ro = 0; res = 0;            end
      endcase
      mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 1);
      r = init;
      foreach (q[n]) begin
         for (int i = 0; i < 8; i++) begin
            b = ri ? q[n][i] : q[n][7-i];
            if (r[w-1] ^ b) r = ((r << 1) & mask) ^ poly;
            else            r = (r << 1) & mask;
         end
      end
      f = 0;
      if (ro) for (int i = 0; i < w; i++) f[i] = r[w-1-i];
      else    f = r;
      crc = f ^ xo;
      m   = (f == res);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nasrt++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the edge that folded the word's final chunk.
   task automatic send_word(input int k, input logic [7:0] d, input logic lst);
      int n = 0;
      din[k] = d; ls[k] = lst; dv[k] = 1'b1;
      while (!rdy[k] && n < 50) begin @(posedge clk); #1; n++; end
      chk("ready_wait", {31'h0, rdy[k]}, 32'h1);
      @(posedge clk); #1;
      dv[k] = 1'b0; ls[k] = 1'b0;
      for (int s = 0; s < steps_of(k) - 1; s++) begin
         chk("busy", {31'h0, rdy[k]}, 32'h0);
         @(posedge clk); #1;
      end
   endtask

   task automatic send_frame(input int k, input bytes_t q, input bit gaps);
      logic [31:0] ec;
      logic        em;
      foreach (q[i]) begin
         if (gaps && $urandom_range(0, 2) == 0)
            repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
         send_word(k, q[i], (i == q.size() - 1));
      end
      model(k, q, ec, em);
      chk("strobe", {31'h0, cvld[k]}, 32'h1);
      chk("crc", crc_w[k], ec);
      chk("match", {31'h0, mt[k]}, {31'h0, em});
      @(posedge clk); #1;
      chk("strobe_one_cycle", {31'h0, cvld[k]}, 32'h0);
      chk("crc_hold", crc_w[k], ec);
   endtask

   task automatic check_reset(input int k);
      chk("rst_ready", {31'h0, rdy[k]}, 32'h1);
      chk("rst_vld", {31'h0, cvld[k]}, 32'h0);
      chk("rst_crc", crc_w[k], 32'h0);
      chk("rst_match", {31'h0, mt[k]}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bytes_t      q9, q;
      logic [31:0] ec, prev;
      logic        em;
      int          nb;

      for (int k = 0; k < 4; k++) begin din[k] = 8'h00; dv[k] = 1'b0; ls[k] = 1'b0; ab[k] = 1'b0; end
      for (int i = 1; i <= 9; i++) q9.push_back(8'(8'h30 + i));

      #1;
      for (int k = 0; k < 4; k++) check_reset(k);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Known-answer frames and residue checks.
      send_frame(0, q9, 0);
      chk("kat_crc8", crc_w[0], 32'hF4);
      q = q9; q.push_back(8'hF4);
      send_frame(0, q, 0);
      chk("kat_crc8_match", {31'h0, mt[0]}, 32'h1);
      q = q9; q.push_back(8'hF5);
      send_frame(0, q, 0);
      chk("kat_crc8_nomatch", {31'h0, mt[0]}, 32'h0);

      send_frame(1, q9, 0);
      chk("kat_crc16", crc_w[1], 32'h29B1);

      send_frame(2, q9, 0);
      chk("kat_crc32", crc_w[2], 32'hCBF43926);
      q = q9; q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
      send_frame(2, q, 0);
      chk("kat_crc32_match", {31'h0, mt[2]}, 32'h1);

      send_frame(3, q9, 0);
      chk("kat_crc8_b2", crc_w[3], 32'hF4);

      // Abort mid-frame together with a valid word.
      prev = crc_w[0];
      for (int i = 0; i < 4; i++) send_word(0, q9[i], 1'b0);
      din[0] = 8'h35; dv[0] = 1'b1; ab[0] = 1'b1;
      @(posedge clk); #1;
      dv[0] = 1'b0; ab[0] = 1'b0;
      chk("abort_no_strobe", {31'h0, cvld[0]}, 32'h0);
      chk("abort_crc_hold", crc_w[0], prev);
      @(posedge clk); #1;
      chk("abort_no_strobe_late", {31'h0, cvld[0]}, 32'h0);
      send_frame(0, q9, 0);
      chk("after_abort", crc_w[0], 32'hF4);

      // Asynchronous reset while instance 3 is mid-SHIFT.
      din[3] = 8'h31; ls[3] = 1'b0; dv[3] = 1'b1;
      @(posedge clk); #1;
      dv[3] = 1'b0;
      chk("in_shift", {31'h0, rdy[3]}, 32'h0);
      #2 rst = 1'b1;
      #1;
      check_reset(3);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      send_frame(3, q9, 0);
      chk("after_reset", crc_w[3], 32'hF4);

      // Random frames with idle gaps, each followed by its own codeword.
      for (int k = 0; k < 4; k++) begin
         for (int f = 0; f < 5; f++) begin
            q = {};
            repeat ($urandom_range(1, 6)) q.push_back(8'($urandom_range(0, 255)));
            send_frame(k, q, 1);
            model(k, q, ec, em);
            nb = (k == 1) ? 2 : (k == 2) ? 4 : 1;
            if (k == 2) for (int i = 0; i < nb; i++)       q.push_back(ec[8*i +: 8]);
            else        for (int i = nb - 1; i >= 0; i--)  q.push_back(ec[8*i +: 8]);
            send_frame(k, q, 1);
            chk("codeword_match", {31'h0, mt[k]}, 32'h1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
      $finish;
   end

endmodule
